// File: rtl/odd_chk_pkg.sv
// Shared definitions for the odd up/down counter sequence checker:
// FSM state encodings, direction encodings and the expected-step helper.
package odd_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Next odd value in the sequence; the caller truncates to its counter
    // width, which gives the 15->1 / 1->15 wrap for free.
    function automatic logic [31:0] next_odd(input logic [31:0] q, input logic dir);
        return (dir == DIR_UP) ? (q + 32'd2) : (q - 32'd2);
    endfunction

endpackage

// File: rtl/odd_seq_checker_sat_counter.sv
// Saturating up counter: increments on inc, holds at all-ones.
module sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] count_q;
    logic [ERR_W-1:0] count_d;

    // Next count: step only while below the saturation value.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {ERR_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/odd_seq_checker.sv
// Monitor for the odd-only +/-2 up/down counter sequence. Tracks lock,
// pulses on step errors while locked, and keeps a saturating error count.
// Build option: define ODD_CHK_STICKY_EN to make ERROR terminal until reset.
module odd_seq_checker
    import odd_chk_pkg::*;
#(
    parameter int W        = 4,
    parameter int ERR_W    = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [W-1:0]     q_in,
    input  logic             dir_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [W-1:0]     last_good
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    state_t          state_q, state_d;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;
    logic [W-1:0]    last_good_q, last_good_d;
    logic            dir_ref_q, dir_ref_d;
    logic            err_pulse_q;
    logic            err_inc;
    logic [W-1:0]    exp_val;
    logic            match;
    logic [GW-1:0]   good_cnt_inc;

    assign exp_val      = W'(next_odd(32'(last_good_q), dir_ref_q));
    assign match        = valid_in & q_in[0] & (q_in == exp_val);
    assign good_cnt_inc = good_cnt_q + 1'b1;

    // Next-state logic; an accepted sample always becomes the new reference.
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        last_good_d = last_good_q;
        dir_ref_d   = dir_ref_q;
        err_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in && q_in[0]) begin
                    state_d     = ST_SYNC;
                    good_cnt_d  = '0;
                    last_good_d = q_in;
                    dir_ref_d   = dir_in;
                end
            end
            ST_SYNC: begin
                if (match) begin
                    last_good_d = q_in;
                    dir_ref_d   = dir_in;
                    if (good_cnt_inc == GW'(LOCK_CNT)) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_inc;
                    end
                end else if (valid_in && q_in[0]) begin
                    good_cnt_d  = '0;
                    last_good_d = q_in;
                    dir_ref_d   = dir_in;
                end else if (valid_in) begin
                    state_d    = ST_IDLE;
                    good_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (match) begin
                    last_good_d = q_in;
                    dir_ref_d   = dir_in;
                end else if (valid_in) begin
                    state_d = ST_ERROR;
                    err_inc = 1'b1;
                end
            end
            ST_ERROR: begin
`ifdef ODD_CHK_STICKY_EN
                state_d = ST_ERROR;
`else
                if (valid_in && q_in[0]) begin
                    state_d     = ST_SYNC;
                    good_cnt_d  = '0;
                    last_good_d = q_in;
                    dir_ref_d   = dir_in;
                end else if (valid_in) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and tracking registers, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            good_cnt_q  <= '0;
            last_good_q <= '0;
            dir_ref_q   <= DIR_UP;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            last_good_q <= last_good_d;
            dir_ref_q   <= dir_ref_d;
            err_pulse_q <= err_inc;
        end
    end

    sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (err_count)
    );

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign last_good = last_good_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed bench for odd_seq_checker: a default instance plus a 2-bit
// error-count instance sharing the same stimulus for saturation checks.
module tb_odd_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       dir_in = 1'b0;

    logic       locked, err_pulse;
    logic [7:0] err_count;
    logic [3:0] last_good;
    logic       s_locked, s_err_pulse;
    logic [1:0] s_err_count;
    logic [3:0] s_last_good;

    int n_vec = 0;
    int n_err = 0;

    odd_seq_checker #(.W(4), .ERR_W(8), .LOCK_CNT(3)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .q_in(q_in), .dir_in(dir_in),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .last_good(last_good)
    );

    odd_seq_checker #(.W(4), .ERR_W(2), .LOCK_CNT(3)) dut_sat (
        .clk(clk), .rst(rst), .valid_in(valid_in), .q_in(q_in), .dir_in(dir_in),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count), .last_good(s_last_good)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample, clock it in, and return 1 time unit after the edge.
    task automatic step(input logic v, input logic [3:0] q, input logic d);
        valid_in = v;
        q_in     = q;
        dir_in   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_last_good", 32'(last_good), 0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // 1. Up lock
        step(1, 1, 0);
        chk("t1_sync_last_good", 32'(last_good), 1);
        step(1, 3, 0);
        step(1, 5, 0);
        chk("t1_not_yet_locked", 32'(locked), 0);
        step(1, 7, 0);
        chk("t1_locked", 32'(locked), 1);
        chk("t1_last_good", 32'(last_good), 7);
        chk("t1_err_count", 32'(err_count), 0);

        // 2. Wrap-around up, then down across the wrap
        step(1, 9, 0);
        step(1, 11, 0);
        step(1, 13, 0);
        step(1, 15, 0);
        step(1, 1, 1);
        chk("t2_wrap_up_pulse", 32'(err_pulse), 0);
        chk("t2_wrap_up_last_good", 32'(last_good), 1);
        step(1, 15, 1);
        chk("t2_wrap_dn_pulse", 32'(err_pulse), 0);
        chk("t2_wrap_dn_locked", 32'(locked), 1);
        chk("t2_wrap_dn_last_good", 32'(last_good), 15);

        // 3. Direction changes
        step(1, 13, 1);
        step(1, 11, 1);
        step(1, 9, 0);
        step(1, 11, 1);
        step(1, 9, 0);
        chk("t3_last_good", 32'(last_good), 9);
        chk("t3_locked", 32'(locked), 1);
        chk("t3_err_count", 32'(err_count), 0);

        // valid_in=0 gap leaves everything unchanged
        step(0, 4, 1);
        step(0, 2, 0);
        chk("gap_last_good", 32'(last_good), 9);
        chk("gap_locked", 32'(locked), 1);
        chk("gap_err_pulse", 32'(err_pulse), 0);

        // 4. Step error while locked at 3
        step(1, 11, 0);
        step(1, 13, 0);
        step(1, 15, 0);
        step(1, 1, 0);
        step(1, 3, 0);
        chk("t4_locked_at_3", 32'(last_good), 3);
        step(1, 7, 0);
        chk("t4_err_pulse", 32'(err_pulse), 1);
        chk("t4_err_count", 32'(err_count), 1);
        chk("t4_unlocked", 32'(locked), 0);
        chk("t4_last_good_held", 32'(last_good), 3);
        step(0, 0, 0);
        chk("t4_pulse_one_cycle", 32'(err_pulse), 0);
        step(1, 9, 0);
        step(1, 11, 0);
        step(1, 13, 0);
        step(1, 15, 0);
`ifdef ODD_CHK_STICKY_EN
        chk("t4_sticky_locked", 32'(locked), 0);
        chk("t4_sticky_err_count", 32'(err_count), 1);
`else
        chk("t4_relocked", 32'(locked), 1);
        chk("t4_relock_last_good", 32'(last_good), 15);
        chk("t4_err_count_kept", 32'(err_count), 1);

        // 5. Saturation: four more lock/error cycles (five errors in total)
        for (int i = 0; i < 4; i++) begin
            step(1, 5, 0);
            chk("t5_err_pulse", 32'(err_pulse), 1);
            step(1, 7, 0);
            step(1, 9, 0);
            step(1, 11, 0);
            step(1, 13, 0);
            chk("t5_relocked", 32'(locked), 1);
        end
        chk("t5_err_count_wide", 32'(err_count), 5);
        chk("t5_err_count_sat", 32'(s_err_count), 3);
`endif

        // 6. Asynchronous reset between edges
        valid_in = 1'b0;
        rst = 1'b1;
        #2;
        chk("t6_rst_locked", 32'(locked), 0);
        chk("t6_rst_err_count", 32'(err_count), 0);
        chk("t6_rst_sat_count", 32'(s_err_count), 0);
        chk("t6_rst_last_good", 32'(last_good), 0);
        chk("t6_rst_err_pulse", 32'(err_pulse), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        step(1, 1, 0);
        step(0, 8, 1);
        step(1, 3, 0);
        step(0, 6, 1);
        step(1, 5, 0);
        chk("t6_not_yet_locked", 32'(locked), 0);
        chk("t6_gap_last_good", 32'(last_good), 5);
        step(1, 7, 0);
        chk("t6_relocked", 32'(locked), 1);
        chk("t6_last_good", 32'(last_good), 7);
        chk("t6_err_count", 32'(err_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
